// File: rtl/seg_capture_decoder_if.sv
// seg_capture_decoder_if
//   Bundles the 7-segment capture bus and the decoded-frame valid/ready output.
//   master : the side that drives the display bus and consumes frames
//            (drives seg_in, dig_sel, ready; observes data_out, err_out, valid, overrun)
//   slave  : the capture decoder itself (the mirror image)
// Parameters:
//   DIGITS : number of multiplexed digits (1..8)
interface seg_capture_decoder_if #(
  parameter int unsigned DIGITS = 4
);
  logic [6:0]          seg_in;    // {g,f,e,d,c,b,a}, 1 = lit
  logic [DIGITS-1:0]   dig_sel;   // one-hot digit select, bit i = digit i
  logic [4*DIGITS-1:0] data_out;  // digit i at [4i+3:4i]
  logic [DIGITS-1:0]   err_out;   // bit i = digit i pattern not decodable
  logic                valid;
  logic                ready;
  logic                overrun;   // sticky, cleared only by reset

  modport master (
    output seg_in,
    output dig_sel,
    output ready,
    input  data_out,
    input  err_out,
    input  valid,
    input  overrun
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    input  ready,
    output data_out,
    output err_out,
    output valid,
    output overrun
  );
endinterface

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder
//   Watches a multiplexed common-cathode 7-segment bus and rebuilds the displayed
//   hex word. Each digit is captured once select and segment lines have been
//   stable for STABLE_CYCLES consecutive sample comparisons, decoded back to a
//   nibble, and the full word is handed out on a valid/ready port.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg_capture_decoder_if.slave (seg_in, dig_sel, ready in;
//           data_out, err_out, valid, overrun out)
// Parameters:
//   DIGITS        : number of digits (1..8)
//   STABLE_CYCLES : stable samples needed before capture (2..255)
// Build option:
//   SEG_CAP_SYNC_EN : when defined, the input stage is a two-flop synchronizer
//                     (latency 2) for buses driven from another clock domain;
//                     otherwise a single register stage (latency 1).
module seg_capture_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input logic                clk,
  input logic                rst_n,
  seg_capture_decoder_if.slave bus
);

  localparam int unsigned SW = DIGITS + 7;
  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]     CntLast  = CW'(STABLE_CYCLES - 1);
  localparam logic [DIGITS-1:0] AllSlots = '1;

  typedef enum logic [0:0] {
    StSettle,
    StHeld
  } state_e;

  // ---------------------------------------------------------------------------
  // Input stage: everything downstream only looks at samp_q.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] raw;
  logic [SW-1:0] samp_q;
  logic [SW-1:0] prev_q;

  assign raw = {bus.dig_sel, bus.seg_in};

`ifdef SEG_CAP_SYNC_EN
  logic [SW-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      samp_q <= '0;
    end else begin
      meta_q <= raw;
      samp_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
    end else begin
      samp_q <= raw;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Segment pattern decode, returns {err, nibble}.
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b0111111: res = 5'h00;
      7'b0000110: res = 5'h01;
      7'b1011011: res = 5'h02;
      7'b1001111: res = 5'h03;
      7'b1100110: res = 5'h04;
      7'b1101101: res = 5'h05;
      7'b1111101: res = 5'h06;
      7'b0000111: res = 5'h07;
      7'b1111111: res = 5'h08;
      7'b1101111: res = 5'h09;
      7'b1110111: res = 5'h0a;
      7'b1111100: res = 5'h0b;
      7'b0111001: res = 5'h0c;
      7'b1011110: res = 5'h0d;
      7'b1111001: res = 5'h0e;
      7'b1110001: res = 5'h0f;
      default:    res = 5'h10;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [DIGITS-1:0]   captured_q;
  logic [4*DIGITS-1:0] stage_data_q;
  logic [DIGITS-1:0]   stage_err_q;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   err_q;
  logic                valid_q;
  logic                overrun_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [6:0]          cur_seg;
  logic [DIGITS-1:0]   cur_sel;
  logic                changed;
  logic                sel_onehot;
  logic [3:0]          dec_nib;
  logic                dec_err;
  logic                window_done;
  logic                cap_en;
  logic [DIGITS-1:0]   mask_next;
  logic                frame_done;
  logic                out_free;
  logic [4*DIGITS-1:0] stage_data_next;
  logic [DIGITS-1:0]   stage_err_next;

  always_comb begin
    cur_seg    = samp_q[6:0];
    cur_sel    = samp_q[SW-1:7];
    changed    = (samp_q != prev_q);
    // Clearing the lowest set bit leaves zero only for a single-bit value.
    sel_onehot = (cur_sel != '0) && ((cur_sel & (cur_sel - DIGITS'(1))) == '0);
    {dec_err, dec_nib} = seg_decode(cur_seg);

    // The window closes on the cycle the counter sits at its last value with
    // the sample still unchanged; only a one-hot select turns that into a capture.
    window_done = (state_q == StSettle) && !changed && (cnt_q == CntLast);
    cap_en      = window_done && sel_onehot;
    mask_next   = captured_q | cur_sel;
    frame_done  = cap_en && (mask_next == AllSlots);
    out_free    = !valid_q || bus.ready;

    stage_data_next = stage_data_q;
    stage_err_next  = stage_err_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cur_sel[i]) begin
        stage_data_next[4*i +: 4] = dec_nib;
        stage_err_next[i]         = dec_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window FSM, staging slots and output frame register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      state_q      <= StSettle;
      cnt_q        <= '0;
      captured_q   <= '0;
      stage_data_q <= '0;
      stage_err_q  <= '0;
      data_q       <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      prev_q <= samp_q;

      unique case (state_q)
        StSettle: begin
          if (changed) begin
            cnt_q <= '0;
          end else if (cnt_q == CntLast) begin
            // Park here so the counter never wraps while the bus stays put.
            state_q <= StHeld;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StHeld: begin
          if (changed) begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
        end
      endcase

      if (cap_en) begin
        stage_data_q <= stage_data_next;
        stage_err_q  <= stage_err_next;
        captured_q   <= frame_done ? '0 : mask_next;
      end

      // A completed frame either replaces the output (free, or consumed this
      // same cycle) or is dropped and flagged.
      if (frame_done) begin
        if (out_free) begin
          data_q  <= stage_data_next;
          err_q   <= stage_err_next;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.err_out  = err_q;
  assign bus.valid    = valid_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: doc/seg_capture_decoder.md
# seg_capture_decoder

Receive-side counterpart of the display encode path: watches a multiplexed, common-cathode 7-segment bus (segment lines plus one-hot digit selects) and reconstructs the displayed hex word. Each digit is sampled once its select and segment lines have been stable for a programmable window, decoded back to a nibble, and the assembled word is delivered on a valid/ready output. Used for loopback self-test of the display drivers and for board-level readback of the scanned display.

## Interface
- DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 8, consecutive identical synchronized samples required before capture (2..255)
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  7  segment lines, bit order {g,f,e,d,c,b,a}, 1 = lit
- dig_sel  input  DIGITS  digit select, active-high, bit i = digit i
- data_out  output  4*DIGITS  decoded word, digit i at [4i+3:4i]
- err_out  output  DIGITS  bit i set = digit i pattern not in decode table
- valid  output  1  data_out/err_out hold a complete frame
- ready  input  1  consumer accepts frame when valid && ready
- overrun  output  1  sticky: a complete frame was dropped

## Operation
- Inputs {dig_sel, seg_in} pass through the input register stage (see Configuration); all logic uses the registered copy.
- Decode table (pattern -> nibble): 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111101->6, 0000111->7, 1111111->8, 1101111->9, 1110111->A, 1111100->B, 0111001->C, 1011110->D, 1111001->E, 1110001->F. Any other pattern -> nibble 0, error bit 1.
- Per-window FSM, states SETTLE and HELD:
  - SETTLE: counter increments while registered sample equals previous sample; any change clears counter to 0. When counter reaches STABLE_CYCLES-1 with dig_sel exactly one-hot, write decoded nibble and error bit into slot i, set captured[i], go to HELD. If not one-hot (zero or multiple bits) at that point, go to HELD without capture.
  - HELD: no further captures; any change of the sample returns to SETTLE with counter 0.
- Re-capturing an already-captured slot overwrites it (latest wins).
- Frame complete when captured mask is all ones: staging slots copied to output registers (if output free), captured mask cleared.
- Output handshake: valid rises with loaded frame; data_out/err_out stable while valid && !ready; frame consumed on valid && ready.
- Frame completes while valid && !ready: new frame discarded, mask cleared, overrun set. Overrun cleared only by reset.
- Frame completes in same cycle as valid && ready: new frame loaded, valid stays 1, no overrun.

## Timing
- Reset values: data_out 0, err_out 0, valid 0, overrun 0; FSM SETTLE, counter 0, captured mask 0, input registers 0.
- Capture cycle: STABLE_CYCLES cycles after the registered sample first shows the new value (counter 0..STABLE_CYCLES-1).
- valid asserts the cycle after the final slot capture.
- Counter width ceil(log2(STABLE_CYCLES)); must never wrap (HELD stops it).
- Reset asserted mid-frame: partial captures and pending output discarded immediately; no valid on release until a full new frame is captured.

## Configuration
- SEG_CAP_SYNC_EN defined: input stage is a two-flop synchronizer per bit; input-to-sample latency 2 cycles. Required when the bus is driven from another clock domain.
- Undefined: single register stage; latency 1 cycle. All other behaviour identical.

## Test plan
- Scan digits 0..3 with patterns for 1,2,3,4, each held 20 cycles, ready=1 -> one valid pulse, data_out=16'h4321, err_out=0.
- Digit 2 driven with 1111001 and digit 0 with 0111001 -> nibbles E and C respectively; digit 1 driven with 0000001 -> nibble 0, err_out[1]=1.
- Segments toggled every 5 cycles with STABLE_CYCLES=8 -> no capture, valid never asserts; dig_sel=4'b0110 held 20 cycles -> no capture.
- ready=0, two complete frames scanned -> first frame held unchanged on data_out, overrun=1; ready=1 then third frame -> third frame delivered, overrun remains 1.
- rst_n pulsed low after 3 of 4 digits captured -> all outputs 0; next full scan alone produces valid with correct word.
- Compile with and without SEG_CAP_SYNC_EN -> capture cycle differs by exactly 1, data identical.
